// File: rtl/cci_mpf_sim_rd_scrambler_pkg.sv
// rtl/cci_mpf_sim_rd_scrambler_pkg.sv - CCI/MPF line types and the rotate-priority picker
package cci_mpf_sim_rd_scrambler_pkg;

  typedef logic [41:0]  t_cci_clAddr;
  typedef logic [15:0]  t_cci_mdata;
  typedef logic [1:0]   t_cci_clNum;
  typedef logic [511:0] t_cci_clData;

  localparam int PICK_W = 256;

  // First set bit of req[width-1:0] at or after start, wrapping; width is a power of 2.
  function automatic logic [7:0] rot_pick(input logic [PICK_W-1:0] req,
                                          input logic [7:0]        start,
                                          input int                width);
    logic found;
    int   idx;
    rot_pick = '0;
    found    = 1'b0;
    for (int k = 0; k < PICK_W; k++) begin
      idx = (int'(start) + k) & (width - 1);
      if (k < width && !found && req[8'(idx)]) begin
        rot_pick = 8'(idx);
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/cci_mpf_sim_lfsr.sv
// rtl/cci_mpf_sim_lfsr.sv - free-running Galois LFSR for simulation shims
module cci_mpf_sim_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h8020_0003)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q >> 1;
    if (state_q[0]) state_d = state_d ^ TAPS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= SEED;
    else          state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/cci_mpf_sim_rd_scrambler.sv
// rtl/cci_mpf_sim_rd_scrambler.sv - read responder returning beats in pseudo-random order
module cci_mpf_sim_rd_scrambler
  import cci_mpf_sim_rd_scrambler_pkg::*;
#(
  parameter int          N_ENTRIES          = 32,
  parameter int          MIN_LATENCY        = 4,
  parameter int          ALM_FULL_THRESHOLD = 8,
  parameter logic [31:0] LFSR_SEED          = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rdReqValid,
  input  t_cci_clAddr rdReqAddr,
  input  t_cci_clNum  rdReqClLen,
  input  t_cci_mdata  rdReqMdata,
  input  logic        rspHold,
  output logic        almFull,
  output logic        rspValid,
  output t_cci_mdata  rspMdata,
  output t_cci_clNum  rspClNum,
  output t_cci_clData rspData,
  output logic        overflow
);

  localparam int IDX_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0] valid_q, valid_d;
  t_cci_clAddr          addr_q  [N_ENTRIES];
  t_cci_clAddr          addr_d  [N_ENTRIES];
  t_cci_mdata           mdata_q [N_ENTRIES];
  t_cci_mdata           mdata_d [N_ENTRIES];
  logic [3:0]           pend_q  [N_ENTRIES];
  logic [3:0]           pend_d  [N_ENTRIES];
  logic [7:0]           age_q   [N_ENTRIES];
  logic [7:0]           age_d   [N_ENTRIES];

  logic        overflow_q, overflow_d;
  logic        alm_full_q, alm_full_d;
  logic        rsp_valid_q, rsp_valid_d;
  t_cci_mdata  rsp_mdata_q, rsp_mdata_d;
  t_cci_clNum  rsp_cl_num_q, rsp_cl_num_d;
  t_cci_clData rsp_data_q, rsp_data_d;

  logic [31:0]          lfsr;
  logic [N_ENTRIES-1:0] free_vec, elig;
  logic [IDX_W-1:0]     alloc_idx, sel_idx;
  t_cci_clNum           beat;
  logic                 sel_go;
  logic [IDX_W:0]       free_cnt;
  logic                 unused_lfsr;

  assign unused_lfsr = ^lfsr;

  cci_mpf_sim_lfsr #(
    .WIDTH (32),
    .SEED  (LFSR_SEED),
    .TAPS  (32'h8020_0003)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .state   (lfsr)
  );

  always_comb begin
    free_vec = ~valid_q;
    for (int i = 0; i < N_ENTRIES; i++)
      elig[i] = valid_q[i] && (pend_q[i] != 4'd0) && (age_q[i] >= 8'(MIN_LATENCY));
    sel_go    = !rspHold && (|elig);
    alloc_idx = IDX_W'(rot_pick(PICK_W'(free_vec), 8'd0, N_ENTRIES));
    sel_idx   = IDX_W'(rot_pick(PICK_W'(elig), 8'(lfsr[IDX_W-1:0]), N_ENTRIES));
    beat      = 2'(rot_pick(PICK_W'(pend_q[sel_idx]), 8'(lfsr[9:8]), 4));

    valid_d    = valid_q;
    addr_d     = addr_q;
    mdata_d    = mdata_q;
    pend_d     = pend_q;
    overflow_d = overflow_q;
    for (int i = 0; i < N_ENTRIES; i++)
      age_d[i] = (valid_q[i] && age_q[i] != 8'hff) ? age_q[i] + 8'd1 : age_q[i];

    if (sel_go) begin
      pend_d[sel_idx][beat] = 1'b0;
      if (pend_d[sel_idx] == 4'd0) valid_d[sel_idx] = 1'b0;
    end

    // Allocation sees only this cycle's free bitmap, so a slot freed above waits a cycle.
    if (rdReqValid) begin
      if (|free_vec) begin
        valid_d[alloc_idx] = 1'b1;
        addr_d[alloc_idx]  = rdReqAddr;
        mdata_d[alloc_idx] = rdReqMdata;
        pend_d[alloc_idx]  = 4'((5'd2 << rdReqClLen) - 5'd1);
        age_d[alloc_idx]   = 8'd0;
      end else begin
        overflow_d = 1'b1;
      end
    end

    free_cnt = '0;
    for (int i = 0; i < N_ENTRIES; i++)
      free_cnt = free_cnt + {{IDX_W{1'b0}}, ~valid_d[i]};
    alm_full_d = int'(free_cnt) <= ALM_FULL_THRESHOLD;

    rsp_valid_d  = sel_go;
    rsp_mdata_d  = rsp_mdata_q;
    rsp_cl_num_d = rsp_cl_num_q;
    rsp_data_d   = rsp_data_q;
    if (sel_go) begin
      rsp_mdata_d  = mdata_q[sel_idx];
      rsp_cl_num_d = beat;
      for (int w = 0; w < 8; w++)
        rsp_data_d[w*64 +: 64] = (64'(addr_q[sel_idx]) + 64'(beat)) ^ (64'(w) << 56);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= '0;
      overflow_q   <= 1'b0;
      alm_full_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_mdata_q  <= '0;
      rsp_cl_num_q <= '0;
      rsp_data_q   <= '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        pend_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      alm_full_q   <= alm_full_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_mdata_q  <= rsp_mdata_d;
      rsp_cl_num_q <= rsp_cl_num_d;
      rsp_data_q   <= rsp_data_d;
      pend_q       <= pend_d;
      age_q        <= age_d;
    end
  end

  // Payload fields are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    mdata_q <= mdata_d;
  end

  assign almFull  = alm_full_q;
  assign overflow = overflow_q;
  assign rspValid = rsp_valid_q;
  assign rspMdata = rsp_mdata_q;
  assign rspClNum = rsp_cl_num_q;
  assign rspData  = rsp_data_q;

endmodule

// File: doc/cci_mpf_sim_rd_scrambler.md
# cci_mpf_sim_rd_scrambler

Simulation and emulation read responder at the FIU end of the MPF read channel. It accepts CCI-P read requests whose Mdata already carries the unique index assigned by the response-ordering shim. It returns one response beat per cycle in pseudo-random order, interleaving beats both across and within multi-line requests. Its purpose is to stress MPF read-ordering logic in unit benches and FPGA self-test builds without a real memory system.

## Interface
- N_ENTRIES, 32: outstanding-request slots; power of 2, ≥ 4.
- MIN_LATENCY, 4: minimum cycles a slot ages before any of its beats may issue; ≥ 1, ≤ 255.
- ALM_FULL_THRESHOLD, 8: almFull asserts when free slots ≤ this value.
- LFSR_SEED, 32'h0000_0001: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- rdReqValid  in  1  read request this cycle; always accepted.
- rdReqAddr  in  42  cache-line address (t_cci_clAddr).
- rdReqClLen  in  2  line count minus 1 (0..3 → 1..4 beats).
- rdReqMdata  in  16  requester tag (t_cci_mdata), returned unchanged.
- rspHold  in  1  when 1, no beat is selected; aging continues.
- almFull  out  1  registered almost-full.
- rspValid  out  1  response beat valid.
- rspMdata  out  16  Mdata of the originating request.
- rspClNum  out  2  beat offset within the request (t_cci_clNum).
- rspData  out  512  generated line data.
- overflow  out  1  sticky: a request arrived with no free slot.

## Operation
- Slot state, per slot: valid, addr, mdata, 4-bit pending beat mask, 8-bit saturating age.
- Allocation:
  - A request takes the lowest-index free slot, computed from the current-cycle free bitmap.
  - pending = (1 << (ClLen+1)) − 1; age = 0.
  - If no slot is free, drop the request and set overflow, which holds until reset.
- Eligibility: eligible[i] = valid & pending ≠ 0 & age ≥ MIN_LATENCY.
- Selection, each cycle with !rspHold and any eligible slot:
  - Start index s = lfsr[log2(N_ENTRIES)−1:0].
  - Pick the first eligible slot at or after s, modulo N_ENTRIES.
  - Within that slot, pick the first pending beat at or after beat lfsr[9:8], modulo 4.
  - Clear the chosen pending bit. When pending reaches 0, clear valid; the slot is reusable the next cycle. The same-cycle free bitmap is not updated.
- Response register: loaded from the selection; rspValid=0 in cycles with no selection.
- Data generation: 64-bit word w (0..7) = 64'(addr + ClNum) ^ (64'(w) << 56).
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances every cycle regardless of traffic.
- almFull: registered (free slot count after this cycle's alloc/free) ≤ ALM_FULL_THRESHOLD.
- Mdata is opaque: never inspected, never compared.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All slots invalid; lfsr = LFSR_SEED.
  - rspValid, rspMdata, rspClNum, rspData, almFull and overflow all 0.
- A request in cycle t is visible with age 0 in cycle t+1. It is first eligible in cycle t+1+MIN_LATENCY.
- Earliest rspValid is cycle t+2+MIN_LATENCY.
- Throughput: at most one beat per cycle. Allocation and selection proceed in parallel each cycle.
- An N-beat request completes no sooner than N cycles after its first beat.
- Simultaneous alloc and free in one cycle: the freed slot is not reused that cycle; the free count reflects both.
- rspHold deasserting resumes selection in the same cycle, so rspValid can assert the next cycle.
- Reset asserted mid-operation discards all outstanding requests. No responses are emitted for them.

## Structure
- t_cci_clAddr, t_cci_mdata, t_cci_clNum and t_cci_clData come from the existing shared CCI/MPF package. Add nothing block-local.
- A sub-module cci_mpf_sim_lfsr (parameters WIDTH, SEED; outputs the state register) is natural and reusable by other sim shims.
- Provide a rotate-priority-pick function, reused for both slot and beat selection.

## Test plan
- Single request: addr 42'h100, ClLen 0, Mdata 16'h0005, MIN_LATENCY 4, request in cycle 10 → exactly one rspValid in cycle 16. Mdata 5, ClNum 0, word0 = 64'h100, word7 = 64'h0700_0000_0000_0100.
- Four-beat request: ClLen 3, addr 42'h200 → four beats in four distinct cycles, ClNum values {0,1,2,3} each exactly once, each word0 = 0x200+ClNum, slot reusable afterwards.
- Fill: hold rspHold=1 and issue 24 single-line requests → almFull=1 the cycle after the 24th request (free = 8). Release hold → all 24 Mdata values return exactly once, order differing from issue order for seed 1.
- Overflow: hold=1, issue 33 requests with N_ENTRIES=32 → overflow=1 from the cycle after the 33rd request, exactly 32 responses after release.
- Reset mid-flight: 10 requests outstanding, pulse reset_n low for 1 cycle → rspValid 0 thereafter, almFull 0, no stale Mdata emitted. A new request returns normally after MIN_LATENCY+2 cycles.
- Back-to-back stress: random requests at ~50% duty for 10k cycles with MIN_LATENCY 1 → a scoreboard sees every (Mdata, ClNum) exactly once with correct data and no beat earlier than request+3 cycles.
